// File: rtl/fft16_if.sv
// Sample-stream and frame handshake bundle between the sample source,
// the 16-point input loader and the parallel FFT core.
interface fft16_if #(
  parameter int N = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [N-1:0]      s_re;
  logic [N-1:0]      s_im;
  logic              s_last;
  logic              o_frame_valid;
  logic              i_frame_ready;
  logic [16*N-1:0]   o_frame_re;
  logic [16*N-1:0]   o_frame_im;
  logic              o_err;

  modport slave (
    input  s_valid, s_re, s_im, s_last, i_frame_ready,
    output s_ready, o_frame_valid, o_frame_re, o_frame_im, o_err
  );

  modport master (
    output s_valid, s_re, s_im, s_last, i_frame_ready,
    input  s_ready, o_frame_valid, o_frame_re, o_frame_im, o_err
  );
endinterface

// File: rtl/fft16_input_loader.sv
// Serial-to-parallel frame loader for the 16-point FFT: collects 16 complex
// samples per frame into one of two ping-pong banks, optionally bit-reversed.

// One FFT lane: one complex entry in each of the two banks.
module fft16_lane #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic         wbank,
  input  logic         rbank,
  input  logic [N-1:0] din_re,
  input  logic [N-1:0] din_im,
  output logic [N-1:0] dout_re,
  output logic [N-1:0] dout_im
);
  logic [1:0][N-1:0] re_q, im_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      re_q <= '0;
      im_q <= '0;
    end else if (we) begin
      re_q[wbank] <= din_re;
      im_q[wbank] <= din_im;
    end
  end

  assign dout_re = re_q[rbank];
  assign dout_im = im_q[rbank];
endmodule

module fft16_input_loader #(
  parameter int N      = 16,
  parameter int Q      = 8,
  parameter int BITREV = 1
) (
  input logic  i_clk,
  input logic  i_rst,
  fft16_if.slave bus
);
  localparam int NUM_LANES = 16;

  if (Q > N) begin : g_q_range
    $error("fft16_input_loader: Q must not exceed N");
  end

  logic [1:0]                      full;
  logic                            wr_ptr, rd_ptr;
  logic [3:0]                      cnt;
  logic                            err;
  logic                            acc, early, commit, cons;
  logic [3:0]                      lane;
  logic [NUM_LANES-1:0]            lane_we;
  logic [NUM_LANES-1:0][N-1:0]     frame_re, frame_im;

  assign bus.s_ready = i_rst & ~full[wr_ptr];
  assign acc         = bus.s_valid & bus.s_ready;
  assign early       = acc & bus.s_last & (cnt != 4'd15);
  assign commit      = acc & (cnt == 4'd15);
  assign cons        = full[rd_ptr] & bus.i_frame_ready;
  assign lane        = (BITREV != 0) ? {cnt[0], cnt[1], cnt[2], cnt[3]} : cnt;

  // Commit and consume always target opposite banks: the write bank is
  // never full while accepting, and the read bank is full while consuming.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      full   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      if (cons) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
      end
      if (commit) begin
        full[wr_ptr] <= 1'b1;
        wr_ptr       <= ~wr_ptr;
      end
      if (early)
        cnt <= '0;
      else if (acc)
        cnt <= cnt + 4'd1;
      if (early | (commit & ~bus.s_last))
        err <= 1'b1;
    end
  end

  // The early-last sample itself is dropped; earlier partial entries are
  // simply overwritten by the next full frame.
  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    assign lane_we[j] = acc & ~early & (lane == 4'(j));

    fft16_lane #(.N(N)) u_lane (
      .clk     (i_clk),
      .rst     (i_rst),
      .we      (lane_we[j]),
      .wbank   (wr_ptr),
      .rbank   (rd_ptr),
      .din_re  (bus.s_re),
      .din_im  (bus.s_im),
      .dout_re (frame_re[j]),
      .dout_im (frame_im[j])
    );
  end

  assign bus.o_frame_valid = full[rd_ptr];
  assign bus.o_frame_re    = frame_re;
  assign bus.o_frame_im    = frame_im;
  assign bus.o_err         = err;
endmodule

// File: tb/tb_fft16_input_loader.sv
// Bench for fft16_input_loader: natural and bit-reversed instances share one
// stimulus stream and are compared against a frame-queue reference model.
module tb_fft16_input_loader;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0, last = 1'b0, fready = 1'b0;
  logic [N-1:0] re = '0, im = '0;

  always #5 clk = ~clk;

  fft16_if #(.N(N)) nat_if ();
  fft16_if #(.N(N)) rev_if ();

  assign nat_if.s_valid = valid;       assign rev_if.s_valid = valid;
  assign nat_if.s_re = re;             assign rev_if.s_re = re;
  assign nat_if.s_im = im;             assign rev_if.s_im = im;
  assign nat_if.s_last = last;         assign rev_if.s_last = last;
  assign nat_if.i_frame_ready = fready; assign rev_if.i_frame_ready = fready;

  fft16_input_loader #(.N(N), .Q(8), .BITREV(0)) u_nat (
    .i_clk(clk), .i_rst(rst_n), .bus(nat_if.slave));
  fft16_input_loader #(.N(N), .Q(8), .BITREV(1)) u_rev (
    .i_clk(clk), .i_rst(rst_n), .bus(rev_if.slave));

  // Reference model: queue of complete frames (sample order) plus the
  // partial frame being collected.
  typedef logic [15:0][2*N-1:0] frame_t;
  frame_t         q[$];
  logic [2*N-1:0] cur[$];
  bit             m_err;
  int             checks = 0, errors = 0;

  function automatic int rev4(input int k);
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
  endfunction

  // Expected parallel bus for the head frame: sample k lands in lane rev4(k).
  function automatic logic [16*N-1:0] exp_lanes(input bit bitrev, input bit imag);
    logic [16*N-1:0] out;
    out = '0;
    if (q.size() == 0) return out;
    for (int k = 0; k < 16; k++) begin
      int ln;
      ln = bitrev ? rev4(k) : k;
      out[ln*N +: N] = imag ? q[0][k][N-1:0] : q[0][k][2*N-1:N];
    end
    return out;
  endfunction

  function automatic bit exp_ready();
    return rst_n && q.size() < 2;
  endfunction

  task automatic drive(input bit v, input logic [N-1:0] r, input logic [N-1:0] i, input bit l);
    valid = v; re = r; im = i; last = l;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); cur.delete(); m_err = 1'b0;
    end else begin
      bit cons, acc, com;
      frame_t nf;
      nf = '0;
      cons = q.size() > 0 && fready;
      acc  = valid && q.size() < 2;
      com  = 1'b0;
      if (acc) begin
        if (last && cur.size() < 15) begin
          cur.delete(); m_err = 1'b1;
        end else begin
          cur.push_back({re, im});
          if (cur.size() == 16) begin
            for (int k = 0; k < 16; k++) nf[k] = cur[k];
            cur.delete(); com = 1'b1;
            if (!last) m_err = 1'b1;
          end
        end
      end
      if (cons) void'(q.pop_front());
      if (com) q.push_back(nf);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fready = 1'b1; drive(1, 16'h1234, 16'h5678, 0);
    tick(); tick();
    checks++; if (nat_if.s_ready !== 1'b0 || rev_if.s_ready !== 1'b0) begin errors++;
      $display("FAIL reset_ready_low: got %b/%b exp 0", nat_if.s_ready, rev_if.s_ready); end
    rst_n = 1'b1; drive(0, 0, 0, 0); fready = 1'b0; #1;
    checks++; if (nat_if.s_ready !== 1'b1 || rev_if.s_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready: got %b/%b exp 1", nat_if.s_ready, rev_if.s_ready); end
    checks++; if (nat_if.o_frame_valid !== 1'b0 || rev_if.o_frame_valid !== 1'b0) begin errors++;
      $display("FAIL reset_fvalid: got %b/%b exp 0", nat_if.o_frame_valid, rev_if.o_frame_valid); end
    checks++; if (nat_if.o_frame_re !== '0 || rev_if.o_frame_im !== '0) begin errors++;
      $display("FAIL reset_data: got %h %h exp 0", nat_if.o_frame_re, rev_if.o_frame_im); end
    checks++; if (nat_if.o_err !== 1'b0 || rev_if.o_err !== 1'b0) begin errors++;
      $display("FAIL reset_err: got %b/%b exp 0", nat_if.o_err, rev_if.o_err); end
  endtask

  task automatic test_natural();
    logic [N-1:0] r3, r8, r12, r15, i3;
    fready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drive(1, N'(k), N'(-k), k == 15);
      checks++; if (nat_if.s_ready !== exp_ready()) begin errors++;
        $display("FAIL nat_ready k=%0d: got %b exp %b", k, nat_if.s_ready, exp_ready()); end
      tick();
    end
    drive(0, 0, 0, 0);
    checks++; if (nat_if.o_frame_valid !== 1'b1 || rev_if.o_frame_valid !== 1'b1) begin errors++;
      $display("FAIL nat_fvalid: got %b/%b exp 1", nat_if.o_frame_valid, rev_if.o_frame_valid); end
    checks++; if (nat_if.o_frame_re !== exp_lanes(0, 0) || nat_if.o_frame_im !== exp_lanes(0, 1)) begin errors++;
      $display("FAIL nat_data: got %h exp %h", nat_if.o_frame_re, exp_lanes(0, 0)); end
    checks++; if (rev_if.o_frame_re !== exp_lanes(1, 0) || rev_if.o_frame_im !== exp_lanes(1, 1)) begin errors++;
      $display("FAIL rev_data: got %h exp %h", rev_if.o_frame_re, exp_lanes(1, 0)); end
    r15 = nat_if.o_frame_re[15*N +: N]; i3 = nat_if.o_frame_im[3*N +: N];
    checks++; if (r15 !== 16'd15 || i3 !== 16'hfffd) begin errors++;
      $display("FAIL nat_lane_const: got %h %h exp 000f fffd", r15, i3); end
    r8 = rev_if.o_frame_re[1*N +: N]; r12 = rev_if.o_frame_re[3*N +: N]; r3 = rev_if.o_frame_re[15*N +: N];
    checks++; if (r8 !== 16'd8 || r12 !== 16'd12 || r3 !== 16'd15) begin errors++;
      $display("FAIL rev_lane_const: got %0d %0d %0d exp 8 12 15", r8, r12, r3); end
    checks++; if (nat_if.o_err !== 1'b0) begin errors++;
      $display("FAIL nat_err: got %b exp 0", nat_if.o_err); end
    tick();
    checks++; if (nat_if.o_frame_valid !== 1'b0 || rev_if.o_frame_valid !== 1'b0) begin errors++;
      $display("FAIL nat_consumed: got %b/%b exp 0", nat_if.o_frame_valid, rev_if.o_frame_valid); end
    fready = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc_cnt;
    acc_cnt = 0; fready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive(1, N'($urandom), N'($urandom), cur.size() == 15);
      checks++; if (nat_if.s_ready !== exp_ready() || rev_if.s_ready !== exp_ready()) begin errors++;
        $display("FAIL bp_ready i=%0d: got %b exp %b", i, nat_if.s_ready, exp_ready()); end
      if (nat_if.s_ready === 1'b1) acc_cnt++;
      tick();
      if (q.size() > 0) begin
        checks++; if (nat_if.o_frame_re !== exp_lanes(0, 0) || rev_if.o_frame_im !== exp_lanes(1, 1)) begin errors++;
          $display("FAIL bp_frameA_stable i=%0d: got %h exp %h", i, nat_if.o_frame_re, exp_lanes(0, 0)); end
      end
    end
    checks++; if (acc_cnt !== 32) begin errors++;
      $display("FAIL bp_accepted: got %0d exp 32", acc_cnt); end
    checks++; if (nat_if.s_ready !== 1'b0) begin errors++;
      $display("FAIL bp_stalled: got %b exp 0", nat_if.s_ready); end
    drive(0, 0, 0, 0); fready = 1'b1;
    tick();
    fready = 1'b0;
    checks++; if (nat_if.o_frame_valid !== 1'b1 || nat_if.s_ready !== 1'b1) begin errors++;
      $display("FAIL bp_frameB_present: got valid %b ready %b exp 1 1", nat_if.o_frame_valid, nat_if.s_ready); end
    checks++; if (nat_if.o_frame_re !== exp_lanes(0, 0) || rev_if.o_frame_re !== exp_lanes(1, 0)) begin errors++;
      $display("FAIL bp_frameB_data: got %h exp %h", nat_if.o_frame_re, exp_lanes(0, 0)); end
    fready = 1'b1; tick(); fready = 1'b0;
    checks++; if (nat_if.o_frame_valid !== 1'b0) begin errors++;
      $display("FAIL bp_drained: got %b exp 0", nat_if.o_frame_valid); end
  endtask

  task automatic test_overlap();
    logic [N-1:0] b0_re;
    b0_re = '0; fready = 1'b0;
    for (int k = 0; k < 32; k++) begin
      drive(1, N'($urandom), N'($urandom), (k % 16) == 15);
      if (k == 16) b0_re = re;
      fready = (k == 31);
      tick();
    end
    drive(0, 0, 0, 0); fready = 1'b0;
    checks++; if (nat_if.o_frame_valid !== 1'b1 || nat_if.s_ready !== 1'b1 || q.size() != 1) begin errors++;
      $display("FAIL ovl_state: got valid %b ready %b exp 1 1", nat_if.o_frame_valid, nat_if.s_ready); end
    checks++; if (nat_if.o_frame_re[N-1:0] !== b0_re || rev_if.o_frame_re[N-1:0] !== b0_re) begin errors++;
      $display("FAIL ovl_lane0: got %h/%h exp %h", nat_if.o_frame_re[N-1:0], rev_if.o_frame_re[N-1:0], b0_re); end
    checks++; if (nat_if.o_frame_im !== exp_lanes(0, 1) || rev_if.o_frame_re !== exp_lanes(1, 0)) begin errors++;
      $display("FAIL ovl_data: got %h exp %h", nat_if.o_frame_im, exp_lanes(0, 1)); end
    fready = 1'b1; tick(); fready = 1'b0;
    checks++; if (nat_if.o_frame_valid !== 1'b0) begin errors++;
      $display("FAIL ovl_no_dup: got %b exp 0", nat_if.o_frame_valid); end
  endtask

  task automatic test_early_last();
    logic [N-1:0] first_re;
    fready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1, N'($urandom), N'($urandom), k == 5);
      tick();
    end
    drive(0, 0, 0, 0);
    checks++; if (nat_if.o_err !== 1'b1 || rev_if.o_err !== 1'b1) begin errors++;
      $display("FAIL early_err: got %b/%b exp 1", nat_if.o_err, rev_if.o_err); end
    checks++; if (nat_if.o_frame_valid !== 1'b0) begin errors++;
      $display("FAIL early_no_frame: got %b exp 0", nat_if.o_frame_valid); end
    first_re = N'($urandom);
    for (int k = 0; k < 16; k++) begin
      drive(1, (k == 0) ? first_re : N'($urandom), N'($urandom), k == 15);
      tick();
    end
    drive(0, 0, 0, 0);
    checks++; if (nat_if.o_frame_valid !== 1'b1 || nat_if.o_frame_re[N-1:0] !== first_re
                  || rev_if.o_frame_re[N-1:0] !== first_re) begin errors++;
      $display("FAIL early_next_lane0: got %b %h exp 1 %h", nat_if.o_frame_valid, nat_if.o_frame_re[N-1:0], first_re); end
    checks++; if (nat_if.o_frame_re !== exp_lanes(0, 0) || rev_if.o_frame_im !== exp_lanes(1, 1)) begin errors++;
      $display("FAIL early_next_data: got %h exp %h", nat_if.o_frame_re, exp_lanes(0, 0)); end
    fready = 1'b1; tick(); fready = 1'b0;
  endtask

  task automatic test_reset_mid();
    fready = 1'b0;
    for (int k = 0; k < 23; k++) begin
      drive(1, N'($urandom), N'($urandom), (k % 16) == 15);
      tick();
    end
    drive(0, 0, 0, 0); rst_n = 1'b0;
    tick();
    rst_n = 1'b1; #1;
    checks++; if (nat_if.o_frame_valid !== 1'b0 || rev_if.o_frame_valid !== 1'b0) begin errors++;
      $display("FAIL rstmid_fvalid: got %b/%b exp 0", nat_if.o_frame_valid, rev_if.o_frame_valid); end
    checks++; if (nat_if.o_frame_re !== '0 || nat_if.o_frame_im !== '0 || rev_if.o_frame_re !== '0) begin errors++;
      $display("FAIL rstmid_data: got %h %h exp 0", nat_if.o_frame_re, nat_if.o_frame_im); end
    checks++; if (nat_if.s_ready !== 1'b1 || nat_if.o_err !== 1'b0) begin errors++;
      $display("FAIL rstmid_ready_err: got %b %b exp 1 0", nat_if.s_ready, nat_if.o_err); end
    for (int k = 0; k < 16; k++) begin
      drive(1, N'($urandom), N'($urandom), k == 15);
      tick();
    end
    drive(0, 0, 0, 0);
    checks++; if (nat_if.o_frame_valid !== 1'b1 || nat_if.o_frame_re !== exp_lanes(0, 0)
                  || rev_if.o_frame_im !== exp_lanes(1, 1)) begin errors++;
      $display("FAIL rstmid_frame: got %b %h exp 1 %h", nat_if.o_frame_valid, nat_if.o_frame_re, exp_lanes(0, 0)); end
    fready = 1'b1; tick(); fready = 1'b0;
  endtask

  task automatic test_missing_last();
    fready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      drive(1, N'($urandom), N'($urandom), 0);
      tick();
      if (k == 14) begin
        checks++; if (nat_if.o_err !== 1'b0) begin errors++;
          $display("FAIL miss_err_early: got %b exp 0", nat_if.o_err); end
      end
    end
    drive(0, 0, 0, 0);
    checks++; if (nat_if.o_err !== 1'b1 || rev_if.o_err !== 1'b1) begin errors++;
      $display("FAIL miss_err: got %b/%b exp 1", nat_if.o_err, rev_if.o_err); end
    checks++; if (nat_if.o_frame_valid !== 1'b1 || rev_if.o_frame_re !== exp_lanes(1, 0)) begin errors++;
      $display("FAIL miss_committed: got %b %h exp 1 %h", nat_if.o_frame_valid, rev_if.o_frame_re, exp_lanes(1, 0)); end
    fready = 1'b1; tick(); fready = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 400; c++) begin
      bit l;
      l = (cur.size() == 15);
      if ($urandom_range(0, 39) == 0) l = ~l;
      drive(($urandom_range(0, 3) != 0), N'($urandom), N'($urandom), l);
      fready = ($urandom_range(0, 3) != 0);
      checks++; if (nat_if.s_ready !== exp_ready() || rev_if.s_ready !== exp_ready()) begin errors++;
        $display("FAIL b2b_ready c=%0d: got %b exp %b", c, nat_if.s_ready, exp_ready()); end
      tick();
      checks++; if (nat_if.o_frame_valid !== (q.size() > 0) || rev_if.o_err !== m_err) begin errors++;
        $display("FAIL b2b_valid_err c=%0d: got %b %b exp %b %b", c, nat_if.o_frame_valid, rev_if.o_err, q.size() > 0, m_err); end
      if (q.size() > 0) begin
        checks++; if (nat_if.o_frame_re !== exp_lanes(0, 0) || nat_if.o_frame_im !== exp_lanes(0, 1)
                      || rev_if.o_frame_re !== exp_lanes(1, 0) || rev_if.o_frame_im !== exp_lanes(1, 1)) begin errors++;
          $display("FAIL b2b_data c=%0d: got %h exp %h", c, rev_if.o_frame_re, exp_lanes(1, 0)); end
      end
    end
    drive(0, 0, 0, 0); fready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_natural();
    test_backpressure();
    test_overlap();
    test_early_last();
    test_reset_mid();
    test_missing_last();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
